// File: rtl/sntc_ldpc_bitflip_decoder.sv
// Hard-decision LDPC bit-flipping decoder. It alternates syndrome and max-unsatisfied flip steps
// until the syndrome clears or MAX_ITER flips have been spent.
module sntc_ldpc_bitflip_decoder #(
  parameter int MM       = 'h000a8,
  parameter int NN       = 'h000d0,
  parameter int cmax     = 'h00017,
  parameter int rmax     = 'h0000a,
  parameter int MAX_ITER = 16,
  parameter int ITW      = $clog2(MAX_ITER + 1),
  parameter int UW       = $clog2(cmax + 1),
  parameter logic [MM*NN-1:0] H_MAT = '0
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           clr,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [NN-1:0]  y_nr_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [NN-1:0]  y_nr_out,
  output logic           dec_ok,
  output logic [ITW-1:0] iter_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, SYN = 2'd1, FLIP = 2'd2, DONE = 2'd3} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [NN-1:0]  r_y;
  logic [MM-1:0]  r_s;
  logic [ITW-1:0] r_iter;
  logic           r_dec_ok;
  logic [MM-1:0]  w_syn;
  logic [UW-1:0]  w_u [NN];
  logic [UW-1:0]  w_umax;
  logic [NN-1:0]  w_flip;
  logic           w_iter_max;

  assign w_iter_max = (r_iter == ITW'(MAX_ITER));

  // Syndrome of the current word, one parity per check row
  always_comb begin
    for (int i = 0; i < MM; i++) begin
      w_syn[i] = ^(H_MAT[i*NN +: NN] & r_y);
    end
  end

  // Per-bit count of unsatisfied checks from the latched syndrome
  always_comb begin
    for (int j = 0; j < NN; j++) begin
      w_u[j] = '0;
      for (int i = 0; i < MM; i++) begin
        w_u[j] = w_u[j] + UW'(H_MAT[i*NN+j] & r_s[i]);
      end
    end
  end

  // Flip mask: every bit tied for the largest unsatisfied count (never all bits when count is 0)
  always_comb begin
    w_umax = '0;
    for (int j = 0; j < NN; j++) begin
      if (w_u[j] > w_umax) begin
        w_umax = w_u[j];
      end else begin
        w_umax = w_umax;
      end
    end
    for (int j = 0; j < NN; j++) begin
      w_flip[j] = (w_u[j] == w_umax) && (w_umax != '0);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) w_next = SYN;
        else          w_next = IDLE;
      end
      SYN: begin
        if (w_syn == '0)     w_next = DONE;
        else if (w_iter_max) w_next = DONE;
        else                 w_next = FLIP;
      end
      FLIP: w_next = SYN;
      DONE: begin
        if (out_ready) w_next = IDLE;
        else           w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Word, syndrome, iteration and status registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_y      <= '0;
      r_s      <= '0;
      r_iter   <= '0;
      r_dec_ok <= 1'b0;
    end else if (clr) begin
      r_y      <= '0;
      r_s      <= '0;
      r_iter   <= '0;
      r_dec_ok <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_y    <= y_nr_in;
            r_iter <= '0;
          end
        end
        SYN: begin
          r_s      <= w_syn;
          r_dec_ok <= (w_syn == '0);
        end
        FLIP: begin
          r_y    <= r_y ^ w_flip;
          r_iter <= r_iter + ITW'(1);
        end
        default: begin
          r_y <= r_y;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign y_nr_out  = r_y;
  assign dec_ok    = r_dec_ok;
  assign iter_cnt  = r_iter;

endmodule

// File: tb/tb_sntc_ldpc_bitflip_decoder.sv
// Scoreboard bench for the bit-flipping decoder on the 7-bit test code, with
// MAX_ITER=16 (dut 0) and MAX_ITER=1 (dut 1) instances.
module tb_sntc_ldpc_bitflip_decoder;
  localparam int NN = 7;
  localparam int MM = 3;
  localparam logic [MM*NN-1:0] H_T = {7'h4E, 7'h2D, 7'h1B};

  logic clk = 1'b0;
  logic rstn;
  logic clr;
  logic [1:0] in_valid, in_ready, out_valid, out_ready, dec_ok;
  logic [NN-1:0] y_in [2];
  logic [NN-1:0] y_out [2];
  logic [4:0] it0;
  logic [0:0] it1;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [NN-1:0] y;
    bit            ok;
    int            it;
    int            cap;
  } exp_t;

  exp_t q0 [$];
  exp_t q1 [$];
  exp_t cur [2];
  bit   seen [2];
  int   rows [3][4] = '{'{0, 1, 3, 4}, '{0, 2, 3, 5}, '{1, 2, 3, 6}};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sntc_ldpc_bitflip_decoder #(.MM(MM), .NN(NN), .cmax(3), .rmax(4), .MAX_ITER(16), .H_MAT(H_T)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .y_nr_in(y_in[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .y_nr_out(y_out[0]), .dec_ok(dec_ok[0]), .iter_cnt(it0));

  sntc_ldpc_bitflip_decoder #(.MM(MM), .NN(NN), .cmax(3), .rmax(4), .MAX_ITER(1), .H_MAT(H_T)) dut_lim (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .y_nr_in(y_in[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .y_nr_out(y_out[1]), .dec_ok(dec_ok[1]), .iter_cnt(it1));

  task automatic chk(input int d, input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL dut%0d %s: got %0h expected %0h", d, name, act, exp);
    end
  endtask

  function automatic int iter_of(input int d);
    if (d == 0) return int'(it0);
    return int'(it1);
  endfunction

  function automatic int qsize(input int d);
    if (d == 0) return q0.size();
    return q1.size();
  endfunction

  // Reference: evaluate check rows as bit lists, flip the most-complained-about bits
  function automatic void ref_decode(input logic [NN-1:0] w, input int max_it,
                                     output logic [NN-1:0] y, output bit ok, output int it);
    int unsat [NN];
    int worst;
    int ones;
    bit bad [3];
    bit any_bad;
    y = w;
    ok = 1'b0;
    it = 0;
    for (int n = 0; n <= max_it; n++) begin
      any_bad = 1'b0;
      for (int r = 0; r < 3; r++) begin
        ones = 0;
        for (int k = 0; k < 4; k++) ones += int'(y[rows[r][k]]);
        bad[r] = (ones % 2) == 1;
        any_bad = any_bad | bad[r];
      end
      if (!any_bad) begin
        ok = 1'b1;
        return;
      end
      if (n == max_it) return;
      worst = 0;
      for (int b = 0; b < NN; b++) begin
        unsat[b] = 0;
        for (int r = 0; r < 3; r++)
          for (int k = 0; k < 4; k++)
            if (bad[r] && rows[r][k] == b) unsat[b]++;
        if (unsat[b] > worst) worst = unsat[b];
      end
      for (int b = 0; b < NN; b++) if (unsat[b] == worst) y[b] = ~y[b];
      it = n + 1;
    end
  endfunction

  task automatic run_word(input int d, input logic [NN-1:0] w, input int hold);
    exp_t e;
    int t;
    chk(d, "in_ready_idle", int'(in_ready[d]), 1);
    ref_decode(w, (d == 0) ? 16 : 1, e.y, e.ok, e.it);
    e.cap = cyc;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    in_valid[d] = 1'b1;
    y_in[d] = w;
    @(negedge clk);
    in_valid[d] = 1'b0;
    t = 0;
    while (!out_valid[d] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid[d]) begin
      chk(d, "out_valid_timeout", int'(out_valid[d]), 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      q0.delete();
      q1.delete();
      return;
    end
    repeat (hold) begin
      in_valid[d] = 1'b1;
      y_in[d] = ~w;
      @(negedge clk);
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk(d, "out_valid_after_handshake", int'(out_valid[d]), 0);
  endtask

  // Monitor: pop on the first out_valid cycle, then hold outputs to that entry
  initial begin : monitor
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rstn === 1'b1 && out_valid[d] === 1'b1) begin
          if (!seen[d]) begin
            seen[d] = 1'b1;
            if (qsize(d) == 0) begin
              chk(d, "queue_nonempty", qsize(d), 1);
              cur[d].y = y_out[d];
              cur[d].ok = dec_ok[d];
              cur[d].it = iter_of(d);
            end else begin
              if (d == 0) cur[d] = q0.pop_front();
              else        cur[d] = q1.pop_front();
              chk(d, "latency", cyc - cur[d].cap, 2 + 2 * cur[d].it);
            end
          end
          chk(d, "y_nr_out", int'(y_out[d]), int'(cur[d].y));
          chk(d, "dec_ok", int'(dec_ok[d]), int'(cur[d].ok));
          chk(d, "iter_cnt", iter_of(d), cur[d].it);
          chk(d, "in_ready_busy", int'(in_ready[d]), 0);
        end else begin
          seen[d] = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rstn = 1'b0;
    clr = 1'b0;
    in_valid = 2'b00;
    out_ready = 2'b00;
    y_in[0] = '0;
    y_in[1] = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_out_valid", int'(out_valid[d]), 0);
      chk(d, "rst_y_nr_out", int'(y_out[d]), 0);
      chk(d, "rst_dec_ok", int'(dec_ok[d]), 0);
      chk(d, "rst_iter_cnt", iter_of(d), 0);
    end
    rstn = 1'b1;
    @(negedge clk);

    run_word(0, 7'h00, 0);
    run_word(0, 7'h31, 1);
    run_word(0, 7'h08, 0);
    run_word(0, 7'h01, 2);
    run_word(1, 7'h01, 0);
    run_word(0, 7'h08, 5);
    for (int n = 0; n < 40; n++) run_word(0, 7'($urandom_range(0, 127)), $urandom_range(0, 3));
    for (int n = 0; n < 10; n++) run_word(1, 7'($urandom_range(0, 127)), $urandom_range(0, 3));

    // Async reset during the second FLIP of 7'h01 (word is 7'h08, iter 1 at this point)
    in_valid[0] = 1'b1;
    y_in[0] = 7'h01;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk(0, "mid_rst_y_nr_out", int'(y_out[0]), 0);
    chk(0, "mid_rst_iter_cnt", iter_of(0), 0);
    chk(0, "mid_rst_dec_ok", int'(dec_ok[0]), 0);
    chk(0, "mid_rst_out_valid", int'(out_valid[0]), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_word(0, 7'h08, 0);

    // Synchronous clear during FLIP, with in_valid high in the same cycle
    in_valid[0] = 1'b1;
    y_in[0] = 7'h01;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    in_valid[0] = 1'b1;
    y_in[0] = 7'h08;
    @(negedge clk);
    clr = 1'b0;
    in_valid[0] = 1'b0;
    chk(0, "clr_y_nr_out", int'(y_out[0]), 0);
    chk(0, "clr_iter_cnt", iter_of(0), 0);
    chk(0, "clr_out_valid", int'(out_valid[0]), 0);
    chk(0, "clr_in_ready", int'(in_ready[0]), 1);

    // Clear while idle blocks a simultaneous capture
    clr = 1'b1;
    in_valid[0] = 1'b1;
    y_in[0] = 7'h08;
    @(negedge clk);
    clr = 1'b0;
    in_valid[0] = 1'b0;
    repeat (3) begin
      chk(0, "clr_no_capture", int'(in_ready[0]), 1);
      @(negedge clk);
    end
    run_word(0, 7'h08, 0);

    repeat (2) @(negedge clk);
    chk(0, "queues_drained", q0.size() + q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
